wbr0_wrapper_boundary_register: RTL and testbench



---
 rtl/wbr0_wrapper_boundary_register_pkg.sv | 32 +++
 rtl/wbr_cell.sv | 40 ++++
 rtl/wbr0_wrapper_boundary_register.sv | 71 +++++++
 tb/tb_wbr0_wrapper_boundary_register.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wbr0_wrapper_boundary_register_pkg.sv
// Shared constants for the core-0 wrapper boundary register: chain length,
// cell positions from WPSI0 towards WPSO0, and the per-cell operation decode.
package wbr0_wrapper_boundary_register_pkg;

    localparam int WBR0_LEN = 7;

    localparam int MBISTDLOGOUT_IDX = 0;
    localparam int MBISTFAIL_IDX    = 1;
    localparam int MBISTDONE_IDX    = 2;
    localparam int BC_IDX           = 3;
    localparam int ACK_IDX          = 4;
    localparam int RX_IDX           = 5;
    localparam int TX_IDX           = 6;

    typedef enum logic [1:0] {
        CELL_CAPTURE = 2'd0,
        CELL_HOLD    = 2'd1,
        CELL_SHIFT   = 2'd2
    } cell_op_e;

    // Shift has priority over hold; capture is the fallback.
    function automatic cell_op_e cell_op(input logic se, input logic hold);
        if (se) begin
            return CELL_SHIFT;
        end else if (hold) begin
            return CELL_HOLD;
        end else begin
            return CELL_CAPTURE;
        end
    endfunction

endpackage

// File: rtl/wbr_cell.sv
// Single boundary cell: one flop with shift/hold/capture next-state select
// and a BusDisable-controlled output mux (fi when transparent, cell when isolated).
module wbr_cell
    import wbr0_wrapper_boundary_register_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic se,
    input  logic hold,
    input  logic si,
    input  logic fi,
    input  logic sel,
    output logic so,
    output logic fo
);

    logic cell_q;
    logic cell_d;

    always_comb begin
        cell_d = fi;
        case (cell_op(se, hold))
            CELL_SHIFT: cell_d = si;
            CELL_HOLD:  cell_d = cell_q;
            default:    cell_d = fi;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cell_q <= 1'b0;
        end else begin
            cell_q <= cell_d;
        end
    end

    assign so = cell_q;
    assign fo = sel ? cell_q : fi;

endmodule

// File: rtl/wbr0_wrapper_boundary_register.sv
// Seven-cell wrapper boundary register for embedded core 0: five core-output
// cells followed by two core-input cells, scanned from WPSI0 to WPSO0.
module wbr0_wrapper_boundary_register
    import wbr0_wrapper_boundary_register_pkg::*;
(
    input  logic CLK,
    input  logic resetn,
    input  logic wse_outputs,
    input  logic hold_outputs,
    input  logic WPSI0,
    input  logic CoreOut_MBISTDLOGOUT,
    input  logic CoreOut_MBISTFAIL,
    input  logic CoreOut_MBISTDone,
    input  logic CoreOut_BC,
    input  logic CoreOut_ACK,
    input  logic RX,
    input  logic TX,
    input  logic BusDisable,
    output logic MBISTDLOGOUT,
    output logic MBISTFAIL,
    output logic MBISTDONE,
    output logic BC,
    output logic ACK,
    output logic CoreIn_RX,
    output logic CoreIn_TX,
    output logic WPSO0
);

    logic [WBR0_LEN-1:0] fi_vec;
    logic [WBR0_LEN-1:0] fo_vec;
    logic [WBR0_LEN-1:0] si_chain;
    logic [WBR0_LEN-1:0] so_chain;

    always_comb begin
        fi_vec                   = '0;
        fi_vec[MBISTDLOGOUT_IDX] = CoreOut_MBISTDLOGOUT;
        fi_vec[MBISTFAIL_IDX]    = CoreOut_MBISTFAIL;
        fi_vec[MBISTDONE_IDX]    = CoreOut_MBISTDone;
        fi_vec[BC_IDX]           = CoreOut_BC;
        fi_vec[ACK_IDX]          = CoreOut_ACK;
        fi_vec[RX_IDX]           = RX;
        fi_vec[TX_IDX]           = TX;
    end

    // Each cell's scan input is the previous cell's flop; c0 takes WPSI0.
    assign si_chain = {so_chain[WBR0_LEN-2:0], WPSI0};

    for (genvar i = 0; i < WBR0_LEN; i++) begin : g_cell
        wbr_cell u_cell (
            .clk    (CLK),
            .resetn (resetn),
            .se     (wse_outputs),
            .hold   (hold_outputs),
            .si     (si_chain[i]),
            .fi     (fi_vec[i]),
            .sel    (BusDisable),
            .so     (so_chain[i]),
            .fo     (fo_vec[i])
        );
    end

    assign MBISTDLOGOUT = fo_vec[MBISTDLOGOUT_IDX];
    assign MBISTFAIL    = fo_vec[MBISTFAIL_IDX];
    assign MBISTDONE    = fo_vec[MBISTDONE_IDX];
    assign BC           = fo_vec[BC_IDX];
    assign ACK          = fo_vec[ACK_IDX];
    assign CoreIn_RX    = fo_vec[RX_IDX];
    assign CoreIn_TX    = fo_vec[TX_IDX];
    assign WPSO0        = so_chain[WBR0_LEN-1];

endmodule

// File: tb/tb_wbr0_wrapper_boundary_register.sv
// Directed bench for the core-0 WBR: reset, shift, capture, hold, transparency,
// priority and mid-shift reset, plus a per-cycle vector table.
module tb_wbr0_wrapper_boundary_register;

    logic CLK = 1'b0;
    logic resetn;
    logic wse_outputs, hold_outputs, WPSI0;
    logic CoreOut_MBISTDLOGOUT, CoreOut_MBISTFAIL, CoreOut_MBISTDone, CoreOut_BC, CoreOut_ACK;
    logic RX, TX, BusDisable;
    logic MBISTDLOGOUT, MBISTFAIL, MBISTDONE, BC, ACK, CoreIn_RX, CoreIn_TX, WPSO0;

    int total = 0;
    int bad   = 0;

    always #10 CLK = ~CLK;

    wbr0_wrapper_boundary_register dut (
        .CLK                  (CLK),
        .resetn               (resetn),
        .wse_outputs          (wse_outputs),
        .hold_outputs         (hold_outputs),
        .WPSI0                (WPSI0),
        .CoreOut_MBISTDLOGOUT (CoreOut_MBISTDLOGOUT),
        .CoreOut_MBISTFAIL    (CoreOut_MBISTFAIL),
        .CoreOut_MBISTDone    (CoreOut_MBISTDone),
        .CoreOut_BC           (CoreOut_BC),
        .CoreOut_ACK          (CoreOut_ACK),
        .RX                   (RX),
        .TX                   (TX),
        .BusDisable           (BusDisable),
        .MBISTDLOGOUT         (MBISTDLOGOUT),
        .MBISTFAIL            (MBISTFAIL),
        .MBISTDONE            (MBISTDONE),
        .BC                   (BC),
        .ACK                  (ACK),
        .CoreIn_RX            (CoreIn_RX),
        .CoreIn_TX            (CoreIn_TX),
        .WPSO0                (WPSO0)
    );

    // Bit i of the vector corresponds to cell ci (0 = MBISTDLOGOUT ... 6 = TX).
    typedef struct {
        logic       wse;
        logic       hold;
        logic       si;
        logic       bd;
        logic [6:0] fi;
        logic       wpso;
        logic [6:0] fo;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] fo_now();
        return {CoreIn_TX, CoreIn_RX, ACK, BC, MBISTDONE, MBISTFAIL, MBISTDLOGOUT};
    endfunction

    task automatic set_fi(input logic [6:0] v);
        {TX, RX, CoreOut_ACK, CoreOut_BC, CoreOut_MBISTDone, CoreOut_MBISTFAIL,
         CoreOut_MBISTDLOGOUT} = v;
    endtask

    task automatic shift_bit(input logic b);
        @(negedge CLK);
        wse_outputs  = 1'b1;
        hold_outputs = 1'b0;
        WPSI0        = b;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [6:0] exp_fo;
        logic [6:0] pat;

        //           wse   hold  si    bd    fi      wpso  fo
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 7'h01};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 7'h02};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 7'h05};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'h33, 1'b0, 7'h33};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'h4C, 1'b0, 7'h33};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 1'b1, 7'h67};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'h2A, 1'b1, 7'h2A};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h55, 1'b1, 7'h55};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'h0F, 1'b0, 7'h2A};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b1, 7'h7F};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 7'h00};

        // Reset with busy inputs; isolated outputs must all read 0.
        resetn       = 1'b0;
        wse_outputs  = 1'b1;
        hold_outputs = 1'b0;
        WPSI0        = 1'b1;
        BusDisable   = 1'b1;
        set_fi(7'h7F);
        #20;
        check("reset_fo_20ns", {1'b0, fo_now()}, 8'h00);
        check("reset_wpso_20ns", {7'b0, WPSO0}, 8'h00);
        #35;
        check("reset_fo_55ns", {1'b0, fo_now()}, 8'h00);
        #5;
        resetn       = 1'b1;
        wse_outputs  = 1'b1;
        hold_outputs = 1'b1;
        WPSI0        = 1'b0;
        #5;
        check("release_fo_pre_edge", {1'b0, fo_now()}, 8'h00);
        check("release_wpso_pre_edge", {7'b0, WPSO0}, 8'h00);

        // Alternating shift: WPSI0 at edge k is (k-1)&1; cell i after edge n holds edge n-i.
        for (int n = 1; n <= 14; n++) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < 7; i++) begin
                exp_fo[i] = (n - i >= 1) ? logic'((n - i - 1) % 2) : 1'b0;
            end
            check($sformatf("alt_fo_edge%0d", n), {1'b0, fo_now()}, {1'b0, exp_fo});
            check($sformatf("alt_wpso_edge%0d", n), {7'b0, WPSO0}, {7'b0, exp_fo[6]});
            @(negedge CLK);
            WPSI0 = logic'(n % 2);
        end

        // Capture CoreOut_*=1, RX=1, TX=0, then unload: TX,RX,ACK,BC,DONE,FAIL,DLOGOUT.
        @(negedge CLK);
        wse_outputs  = 1'b0;
        hold_outputs = 1'b0;
        set_fi(7'h3F);
        @(posedge CLK);
        #1;
        check("cap_wpso_0", {7'b0, WPSO0}, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            shift_bit(1'b0);
            check($sformatf("cap_wpso_%0d", k), {7'b0, WPSO0}, 8'h01);
        end
        shift_bit(1'b0);

        // Load 1010101, then hold for 10 clocks with wandering fi.
        pat = 7'h55;
        for (int k = 6; k >= 0; k--) shift_bit(pat[k]);
        check("hold_loaded", {1'b0, fo_now()}, 8'h55);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            wse_outputs  = 1'b0;
            hold_outputs = 1'b1;
            set_fi(7'(k * 13 + 3));
            @(posedge CLK);
            #1;
            check($sformatf("hold_fo_%0d", k), {1'b0, fo_now()}, 8'h55);
            check($sformatf("hold_wpso_%0d", k), {7'b0, WPSO0}, 8'h01);
        end

        // Transparency with an all-zero chain, then flip BusDisable in the same cycle.
        for (int k = 0; k < 7; k++) shift_bit(1'b0);
        @(negedge CLK);
        wse_outputs  = 1'b0;
        hold_outputs = 1'b1;
        BusDisable   = 1'b0;
        set_fi(7'h5F);
        #1;
        check("transparent_fo", {1'b0, fo_now()}, 8'h5F);
        BusDisable = 1'b1;
        #1;
        check("isolated_fo", {1'b0, fo_now()}, 8'h00);
        check("isolated_wpso", {7'b0, WPSO0}, 8'h00);

        // Per-cycle vector table starting from the all-zero chain.
        for (int v = 0; v < 11; v++) begin
            @(negedge CLK);
            wse_outputs  = vt[v].wse;
            hold_outputs = vt[v].hold;
            WPSI0        = vt[v].si;
            BusDisable   = vt[v].bd;
            set_fi(vt[v].fi);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_fo", v), {1'b0, fo_now()}, {1'b0, vt[v].fo});
            check($sformatf("vec%0d_wpso", v), {7'b0, WPSO0}, {7'b0, vt[v].wpso});
        end

        // Shift beats hold: seven 1s with both enables high.
        BusDisable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLK);
            wse_outputs  = 1'b1;
            hold_outputs = 1'b1;
            WPSI0        = 1'b1;
            set_fi(7'h00);
            @(posedge CLK);
            #1;
        end
        check("prio_fo", {1'b0, fo_now()}, 8'h7F);
        check("prio_wpso", {7'b0, WPSO0}, 8'h01);

        // Asynchronous reset mid-shift, then resume from zero.
        @(negedge CLK);
        #5;
        resetn = 1'b0;
        #1;
        check("midrst_fo", {1'b0, fo_now()}, 8'h00);
        check("midrst_wpso", {7'b0, WPSO0}, 8'h00);
        @(negedge CLK);
        resetn       = 1'b1;
        wse_outputs  = 1'b1;
        hold_outputs = 1'b0;
        WPSI0        = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_resume_fo", {1'b0, fo_now()}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
